// File: rtl/logic_unit_pipe.sv
// logic_unit_pipe
//   Two-stage pipelined bitwise logic unit with valid/ready flow control.
//   Stage 1 captures the result of one of eight bitwise operations. Stage 2
//   captures that result together with its reduction and zero flags. A
//   WIDTH-bit accumulator can stand in for operand A, and a counter tracks
//   completed output handshakes.
//
// Ports
//   iClk, iRst_n          clock, asynchronous active-low reset
//   iValid / oReady       producer handshake (oReady is combinational)
//   iA, iB, iOp           operands and opcode
//   iAcc, iClrAcc         accumulator select / accumulator clear
//   oValid / iReady       consumer handshake
//   oY                    result
//   oRedAnd/Or/Xor, oZero reduction flags of oY
//   oCnt                  completed output handshakes, modulo 2^CNT_W
module logic_unit_pipe #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             iClk,
    input  logic             iRst_n,
    input  logic             iValid,
    output logic             oReady,
    input  logic [WIDTH-1:0] iA,
    input  logic [WIDTH-1:0] iB,
    input  logic [2:0]       iOp,
    input  logic             iAcc,
    input  logic             iClrAcc,
    output logic             oValid,
    input  logic             iReady,
    output logic [WIDTH-1:0] oY,
    output logic             oRedAnd,
    output logic             oRedOr,
    output logic             oRedXor,
    output logic             oZero,
    output logic [CNT_W-1:0] oCnt
);

    logic             v1, v2;
    logic [WIDTH-1:0] y1, y2;
    logic [WIDTH-1:0] acc;
    logic             redAnd, redOr, redXor, zero;
    logic [CNT_W-1:0] cnt;

    logic             ld1, ld2, accept, done;
    logic [WIDTH-1:0] opA, yComb;

    // A stage may load when it is empty or when the stage after it drains
    // this cycle; the iReady -> oReady path is deliberately combinational.
    assign ld2    = !v2 || iReady;
    assign ld1    = !v1 || ld2;
    assign accept = iValid && ld1;
    assign done   = v2 && iReady;

    // A same-cycle clear wins over the stored accumulator value.
    always_comb begin
        opA = iA;
        if (iAcc) begin
            opA = iClrAcc ? '0 : acc;
        end
    end

    always_comb begin
        yComb = '0;
        unique case (iOp)
            3'b000: yComb = opA & iB;
            3'b001: yComb = opA | iB;
            3'b010: yComb = ~opA;
            3'b011: yComb = opA ^ iB;
            3'b100: yComb = ~(opA & iB);
            3'b101: yComb = ~(opA | iB);
            3'b110: yComb = ~(opA ^ iB);
            3'b111: yComb = iB;
            default: yComb = '0;
        endcase
    end

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            v1     <= 1'b0;
            y1     <= '0;
            v2     <= 1'b0;
            y2     <= '0;
            redAnd <= 1'b0;
            redOr  <= 1'b0;
            redXor <= 1'b0;
            zero   <= 1'b0;
        end else begin
            if (ld1) begin
                v1 <= iValid;
            end
            if (accept) begin
                y1 <= yComb;
            end
            if (ld2) begin
                v2 <= v1;
                if (v1) begin
                    y2     <= y1;
                    redAnd <= &y1;
                    redOr  <= |y1;
                    redXor <= ^y1;
                    zero   <= (y1 == '0);
                end
            end
        end
    end

    // The accumulator follows every accepted result at accept time, so a
    // back-to-back accumulator transaction sees its predecessor directly.
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            acc <= '0;
        end else if (accept) begin
            acc <= yComb;
        end else if (iClrAcc) begin
            acc <= '0;
        end
    end

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            cnt <= '0;
        end else if (done) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign oReady  = ld1;
    assign oValid  = v2;
    assign oY      = y2;
    assign oRedAnd = redAnd;
    assign oRedOr  = redOr;
    assign oRedXor = redXor;
    assign oZero   = zero;
    assign oCnt    = cnt;

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Testbench for logic_unit_pipe: directed steps with a scoreboard queue.
// A second instance with a 4-bit counter shares all inputs so counter
// wrap-around can be observed alongside the main instance.
module tb_logic_unit_pipe;

    logic       iClk = 1'b0;
    logic       iRst_n = 1'b0;
    logic       iValid = 1'b0;
    logic       iReady = 1'b0;
    logic       iAcc = 1'b0;
    logic       iClrAcc = 1'b0;
    logic [7:0] iA = '0;
    logic [7:0] iB = '0;
    logic [2:0] iOp = '0;

    logic        oReady, oValid, oRedAnd, oRedOr, oRedXor, oZero;
    logic [7:0]  oY;
    logic [15:0] oCnt;
    logic        sReady, sValid, sRedAnd, sRedOr, sRedXor, sZero;
    logic [7:0]  sY;
    logic [3:0]  sCnt;

    logic_unit_pipe #(.WIDTH(8), .CNT_W(16)) dut (
        .iClk(iClk), .iRst_n(iRst_n), .iValid(iValid), .oReady(oReady),
        .iA(iA), .iB(iB), .iOp(iOp), .iAcc(iAcc), .iClrAcc(iClrAcc),
        .oValid(oValid), .iReady(iReady), .oY(oY), .oRedAnd(oRedAnd),
        .oRedOr(oRedOr), .oRedXor(oRedXor), .oZero(oZero), .oCnt(oCnt)
    );

    logic_unit_pipe #(.WIDTH(8), .CNT_W(4)) dutS (
        .iClk(iClk), .iRst_n(iRst_n), .iValid(iValid), .oReady(sReady),
        .iA(iA), .iB(iB), .iOp(iOp), .iAcc(iAcc), .iClrAcc(iClrAcc),
        .oValid(sValid), .iReady(iReady), .oY(sY), .oRedAnd(sRedAnd),
        .oRedOr(sRedOr), .oRedXor(sRedXor), .oZero(sZero), .oCnt(sCnt)
    );

    always #5 iClk = ~iClk;

    int         nCmp = 0;
    int         nErr = 0;
    logic [7:0] expQ[$];
    int         latQ[$];
    logic [7:0] accM = '0;
    int         cntM = 0;
    int         stepN = 0;
    bit         chkLat = 1'b0;
    bit         prevStall = 1'b0;
    logic [7:0] prevY = '0;
    int         rdyMode = 0;
    bit         accepted = 1'b0;
    bit         sawWrap = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nCmp++;
        assert (obs === exp)
        else begin
            nErr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] refOp(input logic [2:0] op, input logic [7:0] a,
                                         input logic [7:0] b);
        case (op)
            3'd0: return a & b;
            3'd1: return a | b;
            3'd2: return ~a;
            3'd3: return a ^ b;
            3'd4: return ~(a & b);
            3'd5: return ~(a | b);
            3'd6: return ~(a ^ b);
            default: return b;
        endcase
    endfunction

    // One clock cycle: drive at the falling edge, sample 1 ns later,
    // score any output handshake, record any input accept.
    task automatic step(input bit v, input logic [7:0] a, input logic [7:0] b,
                        input logic [2:0] op, input bit ac, input bit clr,
                        input bit useExp, input logic [7:0] expY);
        logic [7:0] effA, y, e;
        int         la;
        bit         rdy;
        rdy = (rdyMode == 1) || (rdyMode == 2 && stepN[0]);
        iValid = v; iA = a; iB = b; iOp = op; iAcc = ac; iClrAcc = clr; iReady = rdy;
        #1;
        accepted = v && oReady;
        if (prevStall) begin
            chk("stallValid", oValid, 1);
            chk("stallY", oY, prevY);
        end
        prevStall = oValid && !rdy;
        prevY = oY;
        if (oValid && rdy) begin
            if (expQ.size() == 0) begin
                chk("spuriousOut", oValid, 0);
            end else begin
                e  = expQ.pop_front();
                la = latQ.pop_front();
                chk("y", oY, e);
                chk("redAnd", oRedAnd, &e);
                chk("redOr", oRedOr, |e);
                chk("redXor", oRedXor, ^e);
                chk("zero", oZero, e == 0);
                chk("cnt", oCnt, cntM[15:0]);
                chk("cntS", sCnt, cntM[3:0]);
                if (cntM[3:0] == 4'hF) sawWrap = 1'b1;
                if (chkLat) chk("latency", stepN - la, 2);
                cntM++;
            end
        end
        if (accepted) begin
            effA = ac ? (clr ? 8'h00 : accM) : a;
            y = refOp(op, effA, b);
            accM = y;
            expQ.push_back(useExp ? expY : y);
            latQ.push_back(stepN);
        end else if (clr) begin
            accM = '0;
        end
        @(negedge iClk);
        stepN++;
    endtask

    task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op,
                        input bit ac, input bit clr, input bit useExp, input logic [7:0] expY);
        accepted = 1'b0;
        for (int k = 0; k < 40 && !accepted; k++) step(1, a, b, op, ac, clr, useExp, expY);
        chk("acceptBound", accepted, 1);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(0, 8'h00, 8'h00, 3'd0, 0, 0, 0, 8'h00);
    endtask

    task automatic drain();
        for (int k = 0; k < 40 && expQ.size() > 0; k++) idle(1);
        chk("drainBound", expQ.size(), 0);
    endtask

    // Asynchronous reset asserted between clock edges.
    task automatic doReset();
        #2;
        iRst_n = 1'b0;
        #1;
        chk("rstValid", oValid, 0);
        chk("rstY", oY, 0);
        chk("rstRedAnd", oRedAnd, 0);
        chk("rstRedOr", oRedOr, 0);
        chk("rstRedXor", oRedXor, 0);
        chk("rstZero", oZero, 0);
        chk("rstCnt", oCnt, 0);
        chk("rstCntS", sCnt, 0);
        chk("rstReady", oReady, 1);
        expQ.delete();
        latQ.delete();
        accM = '0;
        cntM = 0;
        prevStall = 1'b0;
        @(negedge iClk);
        iRst_n = 1'b1;
    endtask

    logic [7:0] opExp[8];

    initial begin
        opExp[0] = 8'h00; opExp[1] = 8'hFF; opExp[2] = 8'h3A; opExp[3] = 8'hFF;
        opExp[4] = 8'hFF; opExp[5] = 8'h00; opExp[6] = 8'h00; opExp[7] = 8'h3A;

        @(negedge iClk);
        doReset();

        // Reset with both stages full under backpressure.
        rdyMode = 0;
        step(1, 8'h12, 8'h34, 3'd3, 0, 0, 0, 8'h00);
        step(1, 8'h56, 8'h78, 3'd1, 0, 0, 0, 8'h00);
        step(1, 8'h9A, 8'hBC, 3'd0, 0, 0, 0, 8'h00);
        chk("fullNoAccept", accepted, 0);
        doReset();
        rdyMode = 1;
        idle(4);

        // All opcodes, free flow, two-cycle latency.
        chkLat = 1'b1;
        for (int i = 0; i < 8; i++) step(1, 8'hC5, 8'h3A, 3'(i), 0, 0, 1, opExp[i]);
        drain();

        // Accumulator chain.
        step(0, 8'h00, 8'h00, 3'd0, 0, 1, 0, 8'h00);
        send(8'hAA, 8'h0F, 3'd3, 1, 0, 1, 8'h0F);
        send(8'h55, 8'hF0, 3'd3, 1, 0, 1, 8'hFF);
        send(8'h33, 8'h00, 3'd2, 1, 0, 1, 8'h00);
        send(8'hCC, 8'h11, 3'd1, 1, 1, 1, 8'h11);
        drain();
        chkLat = 1'b0;

        // Backpressure: two accepts fill the pipe, then toggling drains in order.
        rdyMode = 0;
        step(1, 8'h01, 8'h10, 3'd7, 0, 0, 0, 8'h00);
        chk("bpAcc0", accepted, 1);
        step(1, 8'h02, 8'h20, 3'd7, 0, 0, 0, 8'h00);
        chk("bpAcc1", accepted, 1);
        step(1, 8'h03, 8'h30, 3'd7, 0, 0, 0, 8'h00);
        chk("bpFull", oReady, 0);
        step(1, 8'h03, 8'h30, 3'd7, 0, 0, 0, 8'h00);
        chk("bpStillFull", accepted, 0);
        rdyMode = 2;
        send(8'h03, 8'h30, 3'd7, 0, 0, 0, 8'h00);
        send(8'h04, 8'h40, 3'd7, 0, 0, 0, 8'h00);
        send(8'h05, 8'h50, 3'd7, 0, 0, 0, 8'h00);
        drain();
        chk("bpCount", oCnt, cntM[15:0]);

        // Counter wrap on the 4-bit instance.
        doReset();
        rdyMode = 1;
        sawWrap = 1'b0;
        for (int i = 0; i < 17; i++) send(8'(i), 8'(i * 3), 3'd7, 0, 0, 0, 8'h00);
        drain();
        chk("wrapSeen", sawWrap, 1);
        chk("wrapCntS", sCnt, 1);
        chk("wrapCnt", oCnt, 17);

        // Full-throughput random stream.
        doReset();
        rdyMode = 1;
        chkLat = 1'b1;
        for (int i = 0; i < 100; i++) begin
            step(1, 8'($urandom), 8'($urandom), 3'($urandom_range(0, 7)),
                 1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0), 0, 8'h00);
            chk("rndAccept", accepted, 1);
        end
        drain();
        chk("rndCnt", oCnt, 100);
        chk("rndCntS", sCnt, 4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
        $finish;
    end

endmodule
